lamp_fpu_div_norm_round: RTL and testbench

//   Post-divide stage of the LAMP FPU divider path. Consumes the raw 2*(1+F_DW)-bit

---
 rtl/lamp_fpu_div_norm_round.sv | 236 +++++++++++++++++++++++
 tb/tb_lamp_fpu_div_norm_round.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/lamp_fpu_div_norm_round.sv
// ---------------------------------------------------------------------------
// lamp_fpu_div_norm_round
//
// Post-divide stage of the LAMP FPU divider path. It takes the raw fixed-point
// quotient from the fractional divider, together with the result sign and the
// pre-computed biased exponent. It normalises the quotient, rounds it to
// nearest-even, saturates to Inf or flushes to signed zero on over/underflow,
// and presents the packed float on a valid/ready output buffer.
// Operands reaching this block are finite and nonzero; special values are
// resolved upstream.
//
// Operation sequence (one cycle per arrow):
//   IDLE -(in_valid_i)-> NORM -> ROUND -> DONE -(ready_i)-> IDLE
//
// Ports
//   clk         clock
//   rst         synchronous active-high reset
//   in_valid_i  one-cycle pulse, res_i/exp_i/sign_i valid
//   in_ready_o  high while the block is idle and can accept an operand
//   res_i       quotient, bit[2F+1] weighs 2^0, all lower bits fractional
//   exp_i       signed two's-complement biased exponent (ea - eb + bias)
//   sign_i      result sign
//   result_o    packed float {sign, exponent, fraction}
//   flags_o     {inexact, overflow, underflow}, valid with valid_o
//   valid_o     result available, held until ready_i
//   ready_i     downstream accepts the result
//   ovr_err_o   one-cycle pulse, an operand arrived while the block was busy
// ---------------------------------------------------------------------------
module lamp_fpu_div_norm_round #(
   parameter int unsigned F_DW = 7,
   parameter int unsigned E_DW = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [2*(1+F_DW)-1:0]      res_i,
   input  logic [E_DW+1:0]            exp_i,
   input  logic                       sign_i,
   output logic [E_DW+F_DW:0]         result_o,
   output logic [2:0]                 flags_o,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic                       ovr_err_o
);

   // ------------------------------------------------------------------------
   // Widths and constants
   // ------------------------------------------------------------------------
   localparam int unsigned RW = 2 * (1 + F_DW);   // quotient width
   localparam int unsigned XW = E_DW + 2;         // internal exponent width
   localparam int unsigned OW = 1 + E_DW + F_DW;  // packed float width

   // Signed constants keep every exponent comparison signed; an unsized
   // fill literal would silently turn the compare unsigned.
   localparam logic signed [XW-1:0] EXP_ZERO = '0;
   localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
   localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << E_DW) - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      NORM  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state;
   state_t state_n;

   // ------------------------------------------------------------------------
   // Pipeline registers
   // ------------------------------------------------------------------------
   // Captured operand (loaded on accept)
   logic [RW-1:0]          res_r;
   logic signed [XW-1:0]   exp_r;
   logic                   sign_r;

   // Normalised mantissa with guard/sticky (loaded in NORM)
   logic [F_DW:0]          man_r;
   logic                   g_r;
   logic                   s_r;
   logic signed [XW-1:0]   e_r;

   // Output buffer (loaded in ROUND)
   logic [OW-1:0]          result_r;
   logic [2:0]             flags_r;
   logic                   ovr_err_r;

   // ------------------------------------------------------------------------
   // Combinational next values
   // ------------------------------------------------------------------------
   logic                   lead;
   logic [F_DW:0]          man_n;
   logic                   g_n;
   logic                   s_n;
   logic signed [XW-1:0]   e_n;

   logic                   round_up;
   logic                   carry;
   logic [F_DW-1:0]        frac_n;
   logic signed [XW-1:0]   e_rnd;
   logic                   ovf;
   logic                   unf;
   logic                   inexact;
   logic [OW-1:0]          result_n;
   logic [2:0]             flags_n;

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   // NOTE: every combinational output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (in_valid_i) state_n = NORM;
         NORM:    state_n = ROUND;
         ROUND:   state_n = DONE;
         DONE:    if (ready_i) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs decoded from state
   // ------------------------------------------------------------------------
   always_comb begin
      in_ready_o = 1'b0;
      valid_o    = 1'b0;
      case (state)
         IDLE:    in_ready_o = 1'b1;
         DONE:    valid_o    = 1'b1;
         default: ;
      endcase
   end

   // ------------------------------------------------------------------------
   // Normalise: the quotient lies in (0.5, 2), so at most one left shift is
   // needed. When the integer bit is clear the window slides down one bit
   // and the exponent drops by one to compensate.
   // ------------------------------------------------------------------------
   always_comb begin
      lead  = res_r[RW-1];
      man_n = res_r[RW-1 -: F_DW+1];
      g_n   = res_r[F_DW];
      s_n   = |res_r[F_DW-1:0];
      e_n   = exp_r;
      if (!lead) begin
         man_n = res_r[RW-2 -: F_DW+1];
         g_n   = res_r[F_DW-1];
         s_n   = |res_r[F_DW-2:0];
         e_n   = exp_r - EXP_ONE;
      end
   end

   // ------------------------------------------------------------------------
   // Round to nearest, ties to even, then range check.
   // The increment only carries out of the mantissa when every mantissa bit
   // is set; the fraction then wraps to zero by itself and the exponent
   // absorbs the carry, which matches renormalising 10.000 to 1.000.
   // ------------------------------------------------------------------------
   always_comb begin
      round_up = g_r & (s_r | man_r[0]);
      carry    = round_up & (&man_r);
      frac_n   = man_r[F_DW-1:0] + F_DW'(round_up);
      e_rnd    = e_r + (carry ? EXP_ONE : EXP_ZERO);
      ovf      = (e_rnd >= EXP_MAX);
      unf      = (e_rnd <= EXP_ZERO);
      inexact  = g_r | s_r;

      result_n = {sign_r, e_rnd[E_DW-1:0], frac_n};
      if (ovf) begin
         result_n = {sign_r, {E_DW{1'b1}}, {F_DW{1'b0}}};
      end else if (unf) begin
         // No denormals: flush to zero, keeping the sign.
         result_n = {sign_r, {E_DW{1'b0}}, {F_DW{1'b0}}};
      end
      flags_n = {inexact, ovf, unf};
   end

   // ------------------------------------------------------------------------
   // Datapath registers. Each stage is loaded exactly when its state is
   // active, so stale contents are never observed.
   // ------------------------------------------------------------------------
   // NOTE: these data registers carry no reset; the FSM qualifies their use
   // and reset only needs to return control to IDLE.
   always_ff @(posedge clk) begin
      if (state == IDLE && in_valid_i) begin
         res_r  <= res_i;
         exp_r  <= exp_i;
         sign_r <= sign_i;
      end
      if (state == NORM) begin
         man_r <= man_n;
         g_r   <= g_n;
         s_r   <= s_n;
         e_r   <= e_n;
      end
   end

   // ------------------------------------------------------------------------
   // Output buffer and overrun flag, cleared by reset.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         result_r  <= '0;
         flags_r   <= '0;
         ovr_err_r <= 1'b0;
      end else begin
         // An operand offered while busy is dropped; only the flag records it.
         ovr_err_r <= in_valid_i && (state != IDLE);
         if (state == ROUND) begin
            result_r <= result_n;
            flags_r  <= flags_n;
         end
      end
   end

   assign result_o  = result_r;
   assign flags_o   = flags_r;
   assign ovr_err_o = ovr_err_r;

endmodule

// File: tb/tb_lamp_fpu_div_norm_round.sv
// ---------------------------------------------------------------------------
// tb_lamp_fpu_div_norm_round
//
// Directed bench for the divider post-normalise/round stage with F_DW=7,
// E_DW=8. Each vector carries a hand-computed packed result and flag set.
// ---------------------------------------------------------------------------
module tb_lamp_fpu_div_norm_round;

   logic        clk;
   logic        rst;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [15:0] res_i;
   logic [9:0]  exp_i;
   logic        sign_i;
   logic [15:0] result_o;
   logic [2:0]  flags_o;
   logic        valid_o;
   logic        ready_i;
   logic        ovr_err_o;

   int n_checks = 0;
   int n_errors = 0;

   lamp_fpu_div_norm_round #(
      .F_DW (7),
      .E_DW (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .res_i      (res_i),
      .exp_i      (exp_i),
      .sign_i     (sign_i),
      .result_o   (result_o),
      .flags_o    (flags_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .ovr_err_o  (ovr_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, want);
      end
   endtask

   // Drive one operand, let it be accepted, and wait (bounded) for valid_o.
   // Returns #1 after the edge on which valid_o rose.
   task automatic issue(input string tag, input logic [15:0] r, input logic [9:0] e,
                        input logic s);
      int cnt;
      res_i      = r;
      exp_i      = e;
      sign_i     = s;
      in_valid_i = 1'b1;
      @(posedge clk);
      #1;
      in_valid_i = 1'b0;
      check({tag, ".busy"}, 16'(in_ready_o), 16'd0);
      cnt = 0;
      while (!valid_o && cnt < 10) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      check({tag, ".lat"}, 16'(cnt), 16'd2);
   endtask

   // Full transaction with ready_i held high.
   task automatic run_op(input string tag, input logic [15:0] r, input logic [9:0] e,
                         input logic s, input logic [15:0] want_res, input logic [2:0] want_flg);
      issue(tag, r, e, s);
      check({tag, ".res"}, result_o, want_res);
      check({tag, ".flg"}, 16'(flags_o), 16'(want_flg));
      @(posedge clk);
      #1;
      check({tag, ".idle"}, 16'(in_ready_o), 16'd1);
   endtask

   initial begin
      int highs;
      rst        = 1'b1;
      in_valid_i = 1'b0;
      res_i      = '0;
      exp_i      = '0;
      sign_i     = 1'b0;
      ready_i    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst.ready", 16'(in_ready_o), 16'd1);
      check("rst.valid", 16'(valid_o), 16'd0);
      check("rst.res",   result_o, 16'h0000);
      check("rst.flg",   16'(flags_o), 16'd0);
      check("rst.ovr",   16'(ovr_err_o), 16'd0);
      rst = 1'b0;

      // Exact values, rounding, tie handling, carry-out and range limits.
      run_op("exact",   16'hC000, 10'd127, 1'b0, 16'h3FC0, 3'b000);
      run_op("rnd_up",  16'h5555, 10'd127, 1'b0, 16'h3F2B, 3'b100);
      run_op("tie_odd", 16'h8180, 10'd127, 1'b0, 16'h3F82, 3'b100);
      run_op("tie_evn", 16'h8080, 10'd127, 1'b0, 16'h3F80, 3'b100);
      run_op("carry",   16'hFFFF, 10'd127, 1'b0, 16'h4000, 3'b100);
      run_op("carry_ov",16'hFFFF, 10'd254, 1'b0, 16'h7F80, 3'b110);
      run_op("unf_neg", 16'h5555, 10'd1,   1'b1, 16'h8000, 3'b101);
      run_op("e_min",   16'h5555, 10'd2,   1'b0, 16'h00AB, 3'b100);
      run_op("e_max",   16'hC000, 10'd254, 1'b1, 16'hFF40, 3'b000);
      run_op("big_exp", 16'hC000, 10'd300, 1'b0, 16'h7F80, 3'b010);
      run_op("neg_exp", 16'hC000, 10'h3FB, 1'b0, 16'h0000, 3'b001);

      // Back-pressure in DONE plus an overrun pulse that must be ignored.
      ready_i = 1'b0;
      issue("stall", 16'hC000, 10'd127, 1'b0);
      check("stall.res0", result_o, 16'h3FC0);
      repeat (2) begin
         @(posedge clk);
         #1;
         check("stall.valid", 16'(valid_o), 16'd1);
         check("stall.busy",  16'(in_ready_o), 16'd0);
         check("stall.ovr0",  16'(ovr_err_o), 16'd0);
      end
      res_i      = 16'hFFFF;
      exp_i      = 10'd254;
      sign_i     = 1'b1;
      in_valid_i = 1'b1;
      @(posedge clk);
      #1;
      in_valid_i = 1'b0;
      check("ovr.pulse", 16'(ovr_err_o), 16'd1);
      check("ovr.res",   result_o, 16'h3FC0);
      check("ovr.flg",   16'(flags_o), 16'd0);
      @(posedge clk);
      #1;
      check("ovr.clear", 16'(ovr_err_o), 16'd0);
      @(posedge clk);
      #1;
      check("stall.hold", 16'(valid_o), 16'd1);
      check("stall.res",  result_o, 16'h3FC0);
      ready_i = 1'b1;
      @(posedge clk);
      #1;
      check("drain.ready", 16'(in_ready_o), 16'd1);
      check("drain.valid", 16'(valid_o), 16'd0);

      // Reset while in NORM discards the operand.
      res_i      = 16'h5555;
      exp_i      = 10'd127;
      sign_i     = 1'b0;
      in_valid_i = 1'b1;
      @(posedge clk);
      #1;
      in_valid_i = 1'b0;
      rst        = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mrst.ready", 16'(in_ready_o), 16'd1);
      check("mrst.res",   result_o, 16'h0000);
      highs = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (valid_o) highs++;
      end
      check("mrst.novalid", 16'(highs), 16'd0);

      // Recovery after the mid-operation reset.
      run_op("recover", 16'h8180, 10'd127, 1'b1, 16'hBF82, 3'b100);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
